// File: rtl/adma_dm_width_conv_buf_pkg.sv
// Shared definitions for the datamover width-converting data buffer.
package adma_dm_width_conv_buf_pkg;

  // Conversion mode, fixed at elaboration from the two data widths
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2
  } dm_mode_e;

  // Select the conversion mode from source and destination widths
  function automatic dm_mode_e calc_mode(input int unsigned src_w, input int unsigned dst_w);
    if (dst_w > src_w) return MODE_UP;
    if (src_w > dst_w) return MODE_DOWN;
    return MODE_PASS;
  endfunction

  // Larger width divided by the smaller width
  function automatic int unsigned calc_ratio(input int unsigned src_w, input int unsigned dst_w);
    return (src_w > dst_w) ? (src_w / dst_w) : (dst_w / src_w);
  endfunction

  // Ceiling log2, returns 0 for v <= 1
  function automatic int unsigned calc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Counter width able to index RATIO lanes/slices, never narrower than one bit
  function automatic int unsigned calc_cnt_w(input int unsigned ratio);
    return (calc_clog2(ratio) < 1) ? 1 : calc_clog2(ratio);
  endfunction

  // Byte-strobe width for a data width in bits
  function automatic int unsigned calc_strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/adma_dm_width_conv_buf_fifo.sv
// Synchronous FIFO with count-based full/empty and a registered-storage head.
module adma_dm_width_conv_buf_fifo
  import adma_dm_width_conv_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = calc_clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; cleared on reset so the head reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adma_dm_width_conv_buf.sv
// Datamover data buffer with store-and-forward depth and power-of-two width conversion.
module adma_dm_width_conv_buf
  import adma_dm_width_conv_buf_pkg::*;
#(
  parameter int unsigned ATX_SRC_DATA_W = 256,
  parameter int unsigned ATX_DST_DATA_W = 256,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ATX_SRC_DATA_W-1:0]   src_data,
  input  logic                        src_last,
  input  logic                        src_vld,
  output logic                        src_rdy,
  output logic [ATX_DST_DATA_W-1:0]   dst_data,
  output logic [ATX_DST_DATA_W/8-1:0] dst_strb,
  output logic                        dst_last,
  output logic                        dst_vld,
  input  logic                        dst_rdy,
  output logic                        buf_empty
);

  localparam dm_mode_e    MODE    = calc_mode(ATX_SRC_DATA_W, ATX_DST_DATA_W);
  localparam int unsigned WIDE_W  = (ATX_SRC_DATA_W > ATX_DST_DATA_W) ? ATX_SRC_DATA_W : ATX_DST_DATA_W;
  localparam int unsigned STRB_W  = calc_strb_w(ATX_DST_DATA_W);
  localparam int unsigned ENTRY_W = WIDE_W + 1 + STRB_W;

  logic               rdy_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_en;
  logic               rd_en;
  logic               side_idle;
  logic               src_acc;
  logic               dst_acc;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [WIDE_W-1:0]  head_data;
  logic [STRB_W-1:0]  head_strb;
  logic               head_last;

  assign {head_last, head_strb, head_data} = rd_entry;
  assign src_rdy   = rdy_en & ~fifo_full;
  assign dst_vld   = ~fifo_empty;
  assign dst_strb  = head_strb;
  assign src_acc   = src_vld & src_rdy;
  assign dst_acc   = dst_vld & dst_rdy;
  assign buf_empty = fifo_empty & side_idle;

  // Hold off the source until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  adma_dm_width_conv_buf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  if (MODE == MODE_UP) begin : g_up
    localparam int unsigned RATIO  = calc_ratio(ATX_SRC_DATA_W, ATX_DST_DATA_W);
    localparam int unsigned CNT_W  = calc_cnt_w(RATIO);
    localparam int unsigned LANE_S = ATX_SRC_DATA_W / 8;

    logic [CNT_W-1:0]                    pack_cnt;
    logic [(RATIO-1)*ATX_SRC_DATA_W-1:0] pack_reg;
    logic [WIDE_W-1:0]                   pack_ext;
    logic [WIDE_W-1:0]                   word;
    logic [STRB_W-1:0]                   strb;
    logic                                word_done;

    assign pack_ext  = WIDE_W'(pack_reg);
    assign word_done = (pack_cnt == CNT_W'(RATIO - 1)) | src_last;
    assign wr_en     = src_acc & word_done;
    assign wr_entry  = {src_last, strb, word};
    assign rd_en     = dst_acc;
    assign dst_data  = head_data;
    assign dst_last  = head_last;
    assign side_idle = (pack_cnt == '0);

    // Merge the incoming beat into its lane; strobe covers lanes 0..pack_cnt
    always_comb begin
      word = '0;
      strb = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (CNT_W'(i) == pack_cnt) word[i*ATX_SRC_DATA_W +: ATX_SRC_DATA_W] = src_data;
        else                       word[i*ATX_SRC_DATA_W +: ATX_SRC_DATA_W] = pack_ext[i*ATX_SRC_DATA_W +: ATX_SRC_DATA_W];
        if (CNT_W'(i) <= pack_cnt) strb[i*LANE_S +: LANE_S] = '1;
      end
    end

    // Pack narrow beats LSB lane first; clear once the word is written
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pack_cnt <= '0;
        pack_reg <= '0;
      end else if (src_acc) begin
        if (word_done) begin
          pack_cnt <= '0;
          pack_reg <= '0;
        end else begin
          pack_reg[32'(pack_cnt)*ATX_SRC_DATA_W +: ATX_SRC_DATA_W] <= src_data;
          pack_cnt <= pack_cnt + CNT_W'(1);
        end
      end
    end
  end else if (MODE == MODE_DOWN) begin : g_down
    localparam int unsigned RATIO = calc_ratio(ATX_SRC_DATA_W, ATX_DST_DATA_W);
    localparam int unsigned CNT_W = calc_cnt_w(RATIO);

    logic [CNT_W-1:0] slc_cnt;
    logic             last_slc;

    assign last_slc  = (slc_cnt == CNT_W'(RATIO - 1));
    assign wr_en     = src_acc;
    assign wr_entry  = {src_last, {STRB_W{1'b1}}, src_data};
    assign rd_en     = dst_acc & last_slc;
    assign dst_data  = head_data[32'(slc_cnt)*ATX_DST_DATA_W +: ATX_DST_DATA_W];
    assign dst_last  = head_last & last_slc;
    assign side_idle = (slc_cnt == '0);

    // Step through head slices LSB first; wrap when the entry is popped
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       slc_cnt <= '0;
      else if (dst_acc) slc_cnt <= last_slc ? '0 : slc_cnt + CNT_W'(1);
    end
  end else begin : g_pass
    assign wr_en     = src_acc;
    assign wr_entry  = {src_last, {STRB_W{1'b1}}, src_data};
    assign rd_en     = dst_acc;
    assign dst_data  = head_data;
    assign dst_last  = head_last;
    assign side_idle = 1'b1;
  end

endmodule

// File: tb/tb_adma_dm_width_conv_buf.sv
// Self-checking bench: PASS, UP and DOWN instances driven through a shared scoreboard.
module tb_adma_dm_width_conv_buf;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } src_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   sel   = 0;

  logic [255:0] g_src_data = '0;
  logic         g_src_last = 1'b0;
  logic         g_src_vld  = 1'b0;
  logic         g_dst_rdy  = 1'b0;

  // Selected-instance view
  logic         cur_src_rdy, cur_dst_vld, cur_dst_last, cur_buf_empty;
  logic [255:0] cur_dst_data;
  logic [31:0]  cur_dst_strb;

  // PASS 256/256 depth 4
  logic p_src_vld, p_dst_rdy, p_src_rdy, p_dst_last, p_dst_vld, p_buf_empty;
  logic [255:0] p_dst_data;
  logic [31:0]  p_dst_strb;
  // UP 64->256 depth 4
  logic u_src_vld, u_dst_rdy, u_src_rdy, u_dst_last, u_dst_vld, u_buf_empty;
  logic [255:0] u_dst_data;
  logic [31:0]  u_dst_strb;
  // DOWN 256->64 depth 4
  logic d_src_vld, d_dst_rdy, d_src_rdy, d_dst_last, d_dst_vld, d_buf_empty;
  logic [63:0]  d_dst_data;
  logic [7:0]   d_dst_strb;
  // PASS 256/256 depth 2
  logic b_src_vld, b_dst_rdy, b_src_rdy, b_dst_last, b_dst_vld, b_buf_empty;
  logic [255:0] b_dst_data;
  logic [31:0]  b_dst_strb;

  beat_t exp_q[$];
  src_t  src_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_g = 0, first_acc = -1, first_vld = -1;
  int src_acc_cnt = 0, src_last_cnt = 0, dst_last_cnt = 0;
  logic [255:0] m_acc;
  logic [31:0]  m_strb;
  int           m_lane;

  always #5 clk = ~clk;

  assign p_src_vld = g_src_vld & (sel == 0);
  assign u_src_vld = g_src_vld & (sel == 1);
  assign d_src_vld = g_src_vld & (sel == 2);
  assign b_src_vld = g_src_vld & (sel == 3);
  assign p_dst_rdy = g_dst_rdy & (sel == 0);
  assign u_dst_rdy = g_dst_rdy & (sel == 1);
  assign d_dst_rdy = g_dst_rdy & (sel == 2);
  assign b_dst_rdy = g_dst_rdy & (sel == 3);

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(256), .ATX_DST_DATA_W(256), .FIFO_DEPTH(4)) u_pass (
    .clk(clk), .rst_n(rst_n), .src_data(g_src_data), .src_last(g_src_last), .src_vld(p_src_vld),
    .src_rdy(p_src_rdy), .dst_data(p_dst_data), .dst_strb(p_dst_strb), .dst_last(p_dst_last),
    .dst_vld(p_dst_vld), .dst_rdy(p_dst_rdy), .buf_empty(p_buf_empty));

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(64), .ATX_DST_DATA_W(256), .FIFO_DEPTH(4)) u_up (
    .clk(clk), .rst_n(rst_n), .src_data(g_src_data[63:0]), .src_last(g_src_last), .src_vld(u_src_vld),
    .src_rdy(u_src_rdy), .dst_data(u_dst_data), .dst_strb(u_dst_strb), .dst_last(u_dst_last),
    .dst_vld(u_dst_vld), .dst_rdy(u_dst_rdy), .buf_empty(u_buf_empty));

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(256), .ATX_DST_DATA_W(64), .FIFO_DEPTH(4)) u_down (
    .clk(clk), .rst_n(rst_n), .src_data(g_src_data), .src_last(g_src_last), .src_vld(d_src_vld),
    .src_rdy(d_src_rdy), .dst_data(d_dst_data), .dst_strb(d_dst_strb), .dst_last(d_dst_last),
    .dst_vld(d_dst_vld), .dst_rdy(d_dst_rdy), .buf_empty(d_buf_empty));

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(256), .ATX_DST_DATA_W(256), .FIFO_DEPTH(2)) u_bp (
    .clk(clk), .rst_n(rst_n), .src_data(g_src_data), .src_last(g_src_last), .src_vld(b_src_vld),
    .src_rdy(b_src_rdy), .dst_data(b_dst_data), .dst_strb(b_dst_strb), .dst_last(b_dst_last),
    .dst_vld(b_dst_vld), .dst_rdy(b_dst_rdy), .buf_empty(b_buf_empty));

  // Route the selected instance onto the common observation signals
  always_comb begin
    cur_src_rdy = 1'b0; cur_dst_vld = 1'b0; cur_dst_last = 1'b0; cur_buf_empty = 1'b0;
    cur_dst_data = '0;  cur_dst_strb = '0;
    case (sel)
      0: begin
        cur_src_rdy = p_src_rdy; cur_dst_vld = p_dst_vld; cur_dst_last = p_dst_last;
        cur_buf_empty = p_buf_empty; cur_dst_data = p_dst_data; cur_dst_strb = p_dst_strb;
      end
      1: begin
        cur_src_rdy = u_src_rdy; cur_dst_vld = u_dst_vld; cur_dst_last = u_dst_last;
        cur_buf_empty = u_buf_empty; cur_dst_data = u_dst_data; cur_dst_strb = u_dst_strb;
      end
      2: begin
        cur_src_rdy = d_src_rdy; cur_dst_vld = d_dst_vld; cur_dst_last = d_dst_last;
        cur_buf_empty = d_buf_empty; cur_dst_data = 256'(d_dst_data); cur_dst_strb = 32'(d_dst_strb);
      end
      default: begin
        cur_src_rdy = b_src_rdy; cur_dst_vld = b_dst_vld; cur_dst_last = b_dst_last;
        cur_buf_empty = b_buf_empty; cur_dst_data = b_dst_data; cur_dst_strb = b_dst_strb;
      end
    endcase
  end

  function automatic void add_src(input logic [255:0] d, input logic l);
    src_t s;
    s.data = d; s.last = l;
    src_q.push_back(s);
  endfunction

  function automatic void add_exp(input logic [255:0] d, input logic [31:0] s, input logic l);
    beat_t b;
    b.data = d; b.strb = s; b.last = l;
    exp_q.push_back(b);
  endfunction

  function automatic void clear_state();
    exp_q.delete(); src_q.delete();
    first_acc = -1; first_vld = -1;
    src_acc_cnt = 0; src_last_cnt = 0; dst_last_cnt = 0;
    m_acc = '0; m_strb = '0; m_lane = 0;
  endfunction

  // Reference model: expected destination beats for one accepted source beat
  function automatic void model_push(input int mode, input logic [255:0] d, input logic l);
    if (mode == 0) begin
      add_exp(d, 32'hFFFF_FFFF, l);
    end else if (mode == 1) begin
      m_acc[m_lane*64 +: 64] = d[63:0];
      m_strb[m_lane*8 +: 8]  = 8'hFF;
      if (m_lane == 3 || l) begin
        add_exp(m_acc, m_strb, l);
        m_acc = '0; m_strb = '0; m_lane = 0;
      end else begin
        m_lane++;
      end
    end else begin
      for (int i = 0; i < 4; i++) add_exp(256'(d[i*64 +: 64]), 32'h0000_00FF, l && (i == 3));
    end
  endfunction

  // Drive src_q into the selected instance and score every destination handshake
  task automatic run_stream(input string tag, input int mode, input bit use_model,
                            input int vld_pct, input int rdy_pct, input int budget, input bit must_finish);
    int    cyc;
    bit    done;
    bit    src_fire;
    src_t  s;
    beat_t e;
    cyc = 0; done = 1'b0;
    while (!done && cyc < budget) begin
      if (!g_src_vld && src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
        s = src_q.pop_front();
        g_src_data = s.data; g_src_last = s.last; g_src_vld = 1'b1;
      end
      g_dst_rdy = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cyc++; cyc_g++;
      src_fire = g_src_vld & cur_src_rdy;
      if (src_fire) begin
        src_acc_cnt++;
        if (first_acc < 0) first_acc = cyc_g;
        if (g_src_last) src_last_cnt++;
        if (use_model) model_push(mode, g_src_data, g_src_last);
      end
      if (cur_dst_vld && first_vld < 0) first_vld = cyc_g;
      if (cur_dst_vld && g_dst_rdy) begin
        if (cur_dst_last) dst_last_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected beat: got data=%h strb=%h last=%b, required none", tag,
                   cur_dst_data, cur_dst_strb, cur_dst_last);
        end else begin
          e = exp_q.pop_front();
          if ({cur_dst_data, cur_dst_strb, cur_dst_last} !== {e.data, e.strb, e.last}) begin
            n_fail++;
            $display("FAIL %s beat: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b", tag,
                     cur_dst_data, cur_dst_strb, cur_dst_last, e.data, e.strb, e.last);
          end
        end
      end
      @(posedge clk); #1;
      if (src_fire) g_src_vld = 1'b0;
      done = must_finish && src_q.size() == 0 && !g_src_vld && exp_q.size() == 0 && cur_buf_empty;
    end
    g_dst_rdy = 1'b0;
    if (must_finish && !done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got %0d beats still expected, required 0 within %0d cycles", tag, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; g_src_vld = 1'b0; g_dst_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      n_checks++; if (cur_src_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_src_rdy inst=%0d got=%b required=0", s, cur_src_rdy); end
      n_checks++; if (cur_dst_vld !== 1'b0) begin n_fail++; $display("FAIL reset_dst_vld inst=%0d got=%b required=0", s, cur_dst_vld); end
      n_checks++; if (cur_dst_last !== 1'b0) begin n_fail++; $display("FAIL reset_dst_last inst=%0d got=%b required=0", s, cur_dst_last); end
      n_checks++; if (cur_dst_data !== '0) begin n_fail++; $display("FAIL reset_dst_data inst=%0d got=%h required=0", s, cur_dst_data); end
      n_checks++; if (cur_dst_strb !== '0) begin n_fail++; $display("FAIL reset_dst_strb inst=%0d got=%h required=0", s, cur_dst_strb); end
      n_checks++; if (cur_buf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_buf_empty inst=%0d got=%b required=1", s, cur_buf_empty); end
    end
    sel = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (cur_src_rdy !== 1'b0) begin n_fail++; $display("FAIL release_src_rdy_early got=%b required=0", cur_src_rdy); end
    @(posedge clk); #1;
    n_checks++; if (cur_src_rdy !== 1'b1) begin n_fail++; $display("FAIL release_src_rdy got=%b required=1", cur_src_rdy); end
  endtask

  task automatic test_pass();
    sel = 0; clear_state();
    for (int i = 1; i <= 6; i++) begin
      add_src(256'(i), i == 6);
      add_exp(256'(i), 32'hFFFF_FFFF, i == 6);
    end
    run_stream("pass", 0, 1'b0, 100, 100, 60, 1'b1);
    n_checks++;
    if (first_vld - first_acc !== 1) begin
      n_fail++; $display("FAIL pass_latency got=%0d required=1", first_vld - first_acc);
    end
  endtask

  task automatic test_up();
    sel = 1; clear_state();
    add_src(256'hA, 1'b0); add_src(256'hB, 1'b0); add_src(256'hC, 1'b0); add_src(256'hD, 1'b0);
    add_src(256'hE, 1'b1);
    add_exp({64'hD, 64'hC, 64'hB, 64'hA}, 32'hFFFF_FFFF, 1'b0);
    add_exp({64'h0, 64'h0, 64'h0, 64'hE}, 32'h0000_00FF, 1'b1);
    run_stream("up", 1, 1'b0, 100, 100, 60, 1'b1);
    n_checks++; if (cur_buf_empty !== 1'b1) begin n_fail++; $display("FAIL up_buf_empty got=%b required=1", cur_buf_empty); end
  endtask

  task automatic test_down();
    sel = 2; clear_state();
    add_src({64'h4, 64'h3, 64'h2, 64'h1}, 1'b1);
    add_exp(256'h1, 32'hFF, 1'b0); add_exp(256'h2, 32'hFF, 1'b0);
    add_exp(256'h3, 32'hFF, 1'b0); add_exp(256'h4, 32'hFF, 1'b1);
    run_stream("down", 2, 1'b0, 100, 100, 60, 1'b1);
    n_checks++; if (cur_buf_empty !== 1'b1) begin n_fail++; $display("FAIL down_buf_empty got=%b required=1", cur_buf_empty); end
    n_checks++; if (cur_dst_vld !== 1'b0) begin n_fail++; $display("FAIL down_dst_vld_after got=%b required=0", cur_dst_vld); end
  endtask

  task automatic test_backpressure();
    sel = 3; clear_state();
    for (int i = 1; i <= 3; i++) begin
      add_src(256'(32'h100 + i), i == 3);
      add_exp(256'(32'h100 + i), 32'hFFFF_FFFF, i == 3);
    end
    run_stream("bp_stall", 0, 1'b0, 100, 0, 6, 1'b0);
    n_checks++; if (src_acc_cnt !== 2) begin n_fail++; $display("FAIL bp_accepts got=%0d required=2", src_acc_cnt); end
    n_checks++; if (cur_src_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_src_rdy got=%b required=0", cur_src_rdy); end
    n_checks++; if (cur_dst_data !== 256'h101) begin n_fail++; $display("FAIL bp_head got=%h required=101", cur_dst_data); end
    run_stream("bp_release", 0, 1'b0, 100, 100, 40, 1'b1);
    n_checks++; if (src_acc_cnt !== 3) begin n_fail++; $display("FAIL bp_total_accepts got=%0d required=3", src_acc_cnt); end
  endtask

  task automatic test_random(input int mode, input int n_beats, input string tag);
    sel = mode; clear_state();
    for (int i = 0; i < n_beats; i++)
      add_src({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              ($urandom_range(7) == 0) || (i == n_beats - 1));
    run_stream(tag, mode, 1'b1, 50, 50, 30000, 1'b1);
    n_checks++;
    if (dst_last_cnt !== src_last_cnt) begin
      n_fail++; $display("FAIL %s last_count got=%0d required=%0d", tag, dst_last_cnt, src_last_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    sel = 1; clear_state();
    add_src(256'h31, 1'b0); add_src(256'h32, 1'b0);
    run_stream("rst_fill", 1, 1'b0, 100, 100, 2, 1'b0);
    n_checks++; if (src_acc_cnt !== 2) begin n_fail++; $display("FAIL rst_fill_accepts got=%0d required=2", src_acc_cnt); end
    n_checks++; if (cur_buf_empty !== 1'b0) begin n_fail++; $display("FAIL rst_packing_buf_empty got=%b required=0", cur_buf_empty); end
    rst_n = 1'b0; #1;
    n_checks++; if (cur_dst_vld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dst_vld got=%b required=0", cur_dst_vld); end
    n_checks++; if (cur_buf_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_buf_empty got=%b required=1", cur_buf_empty); end
    n_checks++; if (cur_src_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_src_rdy got=%b required=0", cur_src_rdy); end
    g_src_vld = 1'b0; clear_state();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    add_src(256'h41, 1'b0); add_src(256'h42, 1'b1);
    add_exp({64'h0, 64'h0, 64'h42, 64'h41}, 32'h0000_FFFF, 1'b1);
    run_stream("rst_next", 1, 1'b0, 100, 100, 40, 1'b1);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_up();
    test_down();
    test_backpressure();
    test_random(1, 1000, "rand_up");
    test_random(2, 250, "rand_down");
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
